// File: rtl/plc_pkg.sv
// Shared types and constants for the PLC serial receive path.
// PLC_RX_PARITY_EN adds an even-parity bit after each data frame.
package plc_pkg;

    localparam int PLC_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAR   = 2'd2,
        DONE  = 2'd3
    } rx_state_t;

    // Serial bits per frame: payload plus the optional parity bit.
    function automatic int frame_len(input int data_w, input bit parity_en);
        return data_w + (parity_en ? 1 : 0);
    endfunction

endpackage

// File: rtl/sipo_shreg.sv
// Deserializer datapath: shift register plus count of bits taken so far.
// load starts a new frame with din as its first bit; clr returns to empty.
module sipo_shreg
    import plc_pkg::*;
#(
    parameter int DATA_W    = PLC_DATA_W,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            load,
    input  logic                            shift,
    input  logic                            clr,
    input  logic                            din,
    output logic [DATA_W-1:0]               data,
    output logic [$clog2(DATA_W+1)-1:0]     cnt
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    // First bit is placed so that DATA_W-1 further shifts land it at its final position.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data <= '0;
            cnt  <= '0;
        end else if (load) begin
            data <= MSB_FIRST ? {{(DATA_W-1){1'b0}}, din} : {din, {(DATA_W-1){1'b0}}};
            cnt  <= CNT_W'(1);
        end else if (shift) begin
            data <= MSB_FIRST ? {data[DATA_W-2:0], din} : {din, data[DATA_W-1:1]};
            cnt  <= cnt + CNT_W'(1);
        end else if (clr) begin
            data <= '0;
            cnt  <= '0;
        end
    end

endmodule

// File: rtl/sipo_rx.sv
// Serial-to-parallel receiver feeding the RX FIFO write port.
// Optional even parity per frame when PLC_RX_PARITY_EN is defined (adds parity_err).
module sipo_rx
    import plc_pkg::*;
#(
    parameter int DATA_W    = PLC_DATA_W,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ser_out,
    input  logic              piso_start,
    input  logic              fifo_full,
    output logic              wr_fifo,
    output logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] prl_out,
    output logic              prl_valid,
    output logic              rx_busy,
    output logic              overflow,
    output logic              frame_err
`ifdef PLC_RX_PARITY_EN
    ,
    output logic              parity_err
`endif
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    rx_state_t         state, state_nxt;
    logic [DATA_W-1:0] sr_data;
    logic [CNT_W-1:0]  sr_cnt;
    logic              sr_load, sr_shift, sr_clr;
    logic              last_bit, byte_good;
    logic              wr_nxt, ovf_nxt, ferr_nxt;
`ifdef PLC_RX_PARITY_EN
    logic              par_bit, par_cap, perr_nxt;
`endif

    sipo_shreg #(
        .DATA_W    (DATA_W),
        .MSB_FIRST (MSB_FIRST)
    ) u_shreg (
        .clk   (clk),
        .rst   (rst),
        .load  (sr_load),
        .shift (sr_shift),
        .clr   (sr_clr),
        .din   (ser_out),
        .data  (sr_data),
        .cnt   (sr_cnt)
    );

    assign last_bit = (sr_cnt == CNT_W'(DATA_W - 1));

`ifdef PLC_RX_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          par_bit <= 1'b0;
        else if (par_cap) par_bit <= ser_out;
    end
    assign byte_good = ~(^{sr_data, par_bit});
`else
    assign byte_good = 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // A start pulse always opens a new frame, whatever state it lands in.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (piso_start) state_nxt = SHIFT;
            SHIFT: if (!piso_start && last_bit)
`ifdef PLC_RX_PARITY_EN
                       state_nxt = PAR;
`else
                       state_nxt = DONE;
`endif
`ifdef PLC_RX_PARITY_EN
            PAR:   state_nxt = piso_start ? SHIFT : DONE;
`endif
            DONE:  state_nxt = piso_start ? SHIFT : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        sr_load  = piso_start;
        sr_shift = 1'b0;
        sr_clr   = 1'b0;
        wr_nxt   = 1'b0;
        ovf_nxt  = 1'b0;
        ferr_nxt = 1'b0;
`ifdef PLC_RX_PARITY_EN
        par_cap  = 1'b0;
        perr_nxt = 1'b0;
`endif
        case (state)
            SHIFT: begin
                sr_shift = !piso_start;
                ferr_nxt = piso_start;
            end
`ifdef PLC_RX_PARITY_EN
            PAR: begin
                par_cap  = !piso_start;
                ferr_nxt = piso_start;
            end
`endif
            DONE: begin
                sr_clr  = !piso_start;
                wr_nxt  = byte_good && !fifo_full;
                ovf_nxt = byte_good && fifo_full;
`ifdef PLC_RX_PARITY_EN
                perr_nxt = !byte_good;
`endif
            end
            default: ;
        endcase
    end

    // wr_data/prl_out capture the byte at the same edge the shift register reloads or clears.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_fifo   <= 1'b0;
            prl_valid <= 1'b0;
            overflow  <= 1'b0;
            frame_err <= 1'b0;
            wr_data   <= '0;
            prl_out   <= '0;
        end else begin
            wr_fifo   <= wr_nxt;
            prl_valid <= wr_nxt;
            overflow  <= ovf_nxt;
            frame_err <= ferr_nxt;
            if (wr_nxt) begin
                wr_data <= sr_data;
                prl_out <= sr_data;
            end
        end
    end

`ifdef PLC_RX_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) parity_err <= 1'b0;
        else     parity_err <= perr_nxt;
    end
`endif

    assign rx_busy = (state != IDLE);

endmodule

// File: tb/tb_sipo_rx.sv
// Scoreboard bench for sipo_rx: frame-level stimulus plan builds expected events,
// a negedge monitor compares every cycle against the head of the event queue.
module tb_sipo_rx;

    localparam int  DW   = 8;
    localparam bit  MSBF = 1'b1;
`ifdef PLC_RX_PARITY_EN
    localparam int  FB     = DW + 1;
    localparam bit  PAR_EN = 1'b1;
`else
    localparam int  FB     = DW;
    localparam bit  PAR_EN = 1'b0;
`endif
    localparam int  N = 3000;
    localparam int  K_WR = 0, K_OVF = 1, K_FERR = 2, K_PERR = 3;

    typedef struct {
        int            cyc;
        int            kind;
        logic [DW-1:0] data;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ser_out = 1'b0, piso_start = 1'b0, fifo_full = 1'b0;
    logic wr_fifo, prl_valid, rx_busy, overflow, frame_err, parity_err;
    logic [DW-1:0] wr_data, prl_out;

    // Per-cycle plan: inputs plus the expected busy flag.
    bit st_a [N+64];
    bit bt_a [N+64];
    bit rs_a [N+64];
    bit fl_a [N+64];
    bit bz_a [N+64];

    ev_t           sb [$];
    int            p;
    int            tcur = -1;
    int            n_pass = 0, n_tot = 0;
    logic [DW-1:0] prl_m = '0;

    sipo_rx #(.DATA_W(DW), .MSB_FIRST(MSBF)) dut (
        .clk        (clk),
        .rst        (rst),
        .ser_out    (ser_out),
        .piso_start (piso_start),
        .fifo_full  (fifo_full),
        .wr_fifo    (wr_fifo),
        .wr_data    (wr_data),
        .prl_out    (prl_out),
        .prl_valid  (prl_valid),
        .rx_busy    (rx_busy),
        .overflow   (overflow),
        .frame_err  (frame_err)
`ifdef PLC_RX_PARITY_EN
        ,
        .parity_err (parity_err)
`endif
    );
`ifndef PLC_RX_PARITY_EN
    assign parity_err = 1'b0;
`endif

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int t, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act !== exp)
            $display("FAIL %s cycle=%0d actual=%0h expected=%0h", nm, t, act, exp);
        else
            n_pass++;
    endtask

    // Complete frame starting at cycle p; result appears the cycle after DONE (p+FB).
    task automatic add_full(input logic [DW-1:0] d, input int gap, input int fmode, input bit bad);
        int kind;
        for (int i = 0; i < FB; i++) begin
            st_a[p+i]   = (i == 0);
            bz_a[p+1+i] = 1'b1;
            if (i < DW) bt_a[p+i] = MSBF ? d[DW-1-i] : d[i];
            else        bt_a[p+i] = (^d) ^ bad;
        end
        if (fmode >= 0) fl_a[p+FB] = (fmode == 1);
        if (PAR_EN && bad)   kind = K_PERR;
        else if (fl_a[p+FB]) kind = K_OVF;
        else                 kind = K_WR;
        sb.push_back('{p + FB + 1, kind, d});
        p += FB + gap;
    endtask

    // k bits of a frame, then the next segment's start pulse interrupts it.
    task automatic add_abort(input int k);
        for (int i = 0; i < k; i++) begin
            st_a[p+i]   = (i == 0);
            bz_a[p+1+i] = 1'b1;
        end
        sb.push_back('{p + k + 1, K_FERR, '0});
        p += k;
    endtask

    // k bits of a frame, then reset for two cycles: nothing may come out of it.
    task automatic add_rst(input int k);
        for (int i = 0; i < k; i++) begin
            st_a[p+i] = (i == 0);
            if (i < k - 1) bz_a[p+1+i] = 1'b1;
        end
        rs_a[p+k]   = 1'b1;
        rs_a[p+k+1] = 1'b1;
        p += k + 2;
    endtask

    task automatic gen();
        int  r;
        bit  last_abort;
        for (int t = 0; t < N + 64; t++) begin
            fl_a[t] = ($urandom_range(0, 3) == 0);
            bt_a[t] = ($urandom_range(0, 1) == 1);
        end
        for (int t = 0; t < 3; t++) rs_a[t] = 1'b1;
        p = 4;
        add_full(8'hA5, 2, 0, 1'b0);
        add_full(8'h3C, 0, 0, 1'b0);
        add_full(8'hC3, 3, 0, 1'b0);
        add_full(8'h55, 1, 1, 1'b0);
        add_full(8'h5A, 0, 0, 1'b0);
        add_abort(4);
        add_full(8'h0F, 1, 0, 1'b0);
        add_full(8'h81, 0, 0, 1'b0);
        add_rst(3);
        add_full(8'h96, 1, 0, 1'b0);
`ifdef PLC_RX_PARITY_EN
        add_full(8'h01, 1, 0, 1'b0);
        add_full(8'h01, 1, 0, 1'b1);
`endif
        last_abort = 1'b0;
        while (p < N - 60) begin
            r = $urandom_range(0, 9);
            last_abort = 1'b0;
            if (r < 6)
                add_full(DW'($urandom_range(0, 255)),
                         ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(1, 3),
                         -1, PAR_EN && ($urandom_range(0, 4) == 0));
            else if (r < 9) begin
                add_abort($urandom_range(1, FB - 1));
                last_abort = 1'b1;
            end else
                add_rst($urandom_range(2, FB - 1));
        end
        if (last_abort) add_full(8'h3E, 2, 0, 1'b0);
    endtask

    initial begin
        gen();
        for (int t = 0; t < N; t++) begin
            @(posedge clk);
            #1;
            rst        = rs_a[t];
            piso_start = st_a[t];
            ser_out    = bt_a[t];
            fifo_full  = fl_a[t];
            tcur       = t;
        end
        @(negedge clk);
        #1;
        tcur = -1;
        chk("sb_drained", N, sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

    initial begin
        ev_t         e;
        logic [4:0]  exp_f;
        forever begin
            @(negedge clk);
            if (tcur >= 0) begin
                if (rs_a[tcur]) begin
                    prl_m = '0;
                    chk("reset_outputs", tcur,
                        {wr_fifo, prl_valid, overflow, frame_err, parity_err, rx_busy, wr_data, prl_out}, 0);
                end else begin
                    exp_f = 5'b0;
                    e = '{-1, -1, '0};
                    if (sb.size() > 0 && sb[0].cyc == tcur) begin
                        e = sb.pop_front();
                        case (e.kind)
                            K_WR:    begin exp_f = 5'b11000; prl_m = e.data; end
                            K_OVF:   exp_f = 5'b00100;
                            K_FERR:  exp_f = 5'b00010;
                            default: exp_f = 5'b00001;
                        endcase
                    end
                    chk("pulses{wr,pv,ovf,ferr,perr}", tcur,
                        {wr_fifo, prl_valid, overflow, frame_err, parity_err}, exp_f);
                    if (e.kind == K_WR) chk("wr_data", tcur, wr_data, e.data);
                    chk("prl_out", tcur, prl_out, prl_m);
                    chk("rx_busy", tcur, rx_busy, bz_a[tcur]);
                end
            end
        end
    end

endmodule
